// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC sequencing controller and the PC mux.
package pc_ctrl_pkg;

   localparam logic [1:0] PC_SRC_RESET       = 2'b00;
   localparam logic [1:0] PC_SRC_TRAP_RETURN = 2'b01;
   localparam logic [1:0] PC_SRC_TRAP_TAKEN  = 2'b10;
   localparam logic [1:0] PC_SRC_OPERATING   = 2'b11;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_TRAP,
      ST_TRET
   } state_e;

   typedef enum logic {
      CAUSE_CSR        = 1'b0,
      CAUSE_MISALIGNED = 1'b1
   } trap_cause_e;

   function automatic logic [1:0] pc_src_of(input state_e st);
      case (st)
         ST_BOOT: pc_src_of = PC_SRC_RESET;
         ST_RUN:  pc_src_of = PC_SRC_OPERATING;
         ST_TRAP: pc_src_of = PC_SRC_TRAP_TAKEN;
         default: pc_src_of = PC_SRC_TRAP_RETURN;
      endcase
   endfunction

endpackage

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: owns the PC, selects the PC-mux source and
// arbitrates traps, mret, stalls and fetch acknowledge.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] pc_mux_in,
   input  logic        misaligned_instr_in,
   input  logic        trap_req_in,
   input  logic        mret_in,
   input  logic        stall_in,
   input  logic        i_ack_in,
   output logic [1:0]  pc_src_out,
   output logic [31:0] pc_out,
   output logic        i_req_out,
   output logic [31:0] epc_out,
   output logic        trap_taken_out,
   output logic        trap_cause_out,
   output logic        flush_out
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic        cause_q, cause_d;
   logic        taken_q, taken_d;
   logic        flush_q, flush_d;
   logic        i_req_q, i_req_d;
   logic [1:0]  pc_src_q, pc_src_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      taken_d = 1'b0;
      case (state_q)
         ST_BOOT: begin
            pc_d    = pc_mux_in;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A misaligned target traps before it can ever reach the PC.
            if (trap_req_in) begin
               epc_d   = pc_q;
               cause_d = CAUSE_CSR;
               taken_d = 1'b1;
               state_d = ST_TRAP;
            end else if (misaligned_instr_in && i_ack_in && !stall_in) begin
               epc_d   = pc_q;
               cause_d = CAUSE_MISALIGNED;
               taken_d = 1'b1;
               state_d = ST_TRAP;
            end else if (mret_in) begin
               state_d = ST_TRET;
            end else if (!stall_in && i_ack_in) begin
               pc_d = pc_mux_in;
            end
         end
         ST_TRAP, ST_TRET: begin
            pc_d    = pc_mux_in;
            state_d = ST_RUN;
         end
         default: state_d = ST_BOOT;
      endcase
      // Outputs are registered, so they are decoded from the next state.
      pc_src_d = pc_src_of(state_d);
      i_req_d  = (state_d == ST_RUN);
      flush_d  = (state_d == ST_TRAP) || (state_d == ST_TRET);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         epc_q    <= '0;
         cause_q  <= 1'b0;
         taken_q  <= 1'b0;
         flush_q  <= 1'b0;
         i_req_q  <= 1'b0;
         pc_src_q <= PC_SRC_RESET;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         taken_q  <= taken_d;
         flush_q  <= flush_d;
         i_req_q  <= i_req_d;
         pc_src_q <= pc_src_d;
      end
   end

   assign pc_src_out     = pc_src_q;
   assign pc_out         = pc_q;
   assign i_req_out      = i_req_q;
   assign epc_out        = epc_q;
   assign trap_taken_out = taken_q;
   assign trap_cause_out = cause_q;
   assign flush_out      = flush_q;

endmodule
